serial_msg_sink: RTL
====================

SERIAL_MSG_SINK -- requirements
Module: serial_msg_sink

Downstream consumer of the 64-bit serial receiver output. It filters CRC-failed messages, buffers good messages in a small FIFO with a valid/ready output, keeps frame statistics and tracks link liveness.

Interface
REQ-001 Parameters SHALL be:
- AW, default 2, log2 of FIFO depth (depth = 2^AW).
- LINK_TO, default 500000, idle clk cycles without a good frame before link_up drops.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sync  in  1  one-cycle message-complete strobe from the receiver.
- d  in  64  received message, valid in the cycle sync=1.
- err  in  1  CRC error flag, valid in the cycle sync=1.
- clr  in  1  synchronous flush of the FIFO and all counters.
- m_valid  out  1  head entry available.
- m_data  out  64  head entry.
- m_ready  in  1  consumer accepts the head entry.
- level  out  AW+1  current FIFO occupancy.
- good_cnt  out  16  count of CRC-good frames.
- bad_cnt  out  16  count of CRC-failed frames.
- drop_cnt  out  16  count of good frames lost because the FIFO was full.
- link_up  out  1  good frame seen within the last LINK_TO cycles.

Function
REQ-003 A frame SHALL be accepted only in a cycle with sync=1; d and err SHALL be sampled in that same cycle and ignored otherwise.
REQ-004 A frame with sync=1 and err=0 (good frame) SHALL increment good_cnt; if the FIFO is not full it SHALL be written, otherwise drop_cnt SHALL increment and the frame is discarded.
REQ-005 A frame with sync=1 and err=1 SHALL increment bad_cnt and SHALL never be written to the FIFO.
REQ-006 The FIFO SHALL be first-word fall-through: m_valid = (level != 0), and m_data = oldest entry, registered, with no combinational path from d.
REQ-007 A pop SHALL occur when m_valid=1 and m_ready=1, advancing to the next entry on the following cycle.
REQ-008 Latency SHALL be exactly 1 clk: a good frame written into an empty FIFO at cycle N gives m_valid=1 and m_data=d at cycle N+1.
REQ-009 m_data and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-010 Full FIFO with push and pop in the same cycle: the pop SHALL free the slot, the push SHALL be accepted, level SHALL be unchanged and drop_cnt SHALL not increment.
REQ-011 Empty FIFO with a push: m_ready SHALL be ignored that cycle (no pop), and level SHALL become 1.
REQ-012 Read and write pointers SHALL be AW bits wide and wrap modulo 2^AW; level SHALL range 0..2^AW.
REQ-013 All three counters SHALL saturate at 16'hFFFF and never wrap.
REQ-014 Link watchdog:
- a cycle counter of at least 20 bits SHALL reset to 0 on every good frame and otherwise count up, saturating at LINK_TO;
- link_up SHALL be set the cycle after a good frame;
- link_up SHALL clear when the counter reaches LINK_TO;
- bad frames SHALL not affect the watchdog.
REQ-015 clr=1 SHALL, in that cycle:
- empty the FIFO and zero all counters;
- clear link_up and set the watchdog counter to LINK_TO;
- take priority over any simultaneous push, pop or count, so a frame arriving with clr is discarded and not counted.

Reset
REQ-016 On rst_n=0, asynchronously:
- m_valid=0, m_data=0, level=0;
- good_cnt=0, bad_cnt=0, drop_cnt=0;
- link_up=0, watchdog counter=LINK_TO, pointers=0.
REQ-017 Reset deasserted mid-operation SHALL leave no stale FIFO entry visible; the first frame after reset SHALL be processed normally.
REQ-018 FIFO storage RAM SHALL not require reset; only pointers, counters and flags SHALL be reset.

Verification
REQ-019 Good frame: sync=1, err=0, d=64'h0123456789ABCDEF, m_ready=0 -> next cycle m_valid=1, m_data=64'h0123456789ABCDEF, level=1, good_cnt=1, link_up=1.
REQ-020 Bad frame: sync=1, err=1 -> m_valid stays 0, bad_cnt=1, good_cnt=0, level=0.
REQ-021 Overflow (AW=2, m_ready=0): 6 good frames -> level=4, drop_cnt=2, good_cnt=6, and the entries popped are frames 1-4 in order.
REQ-022 Full FIFO with sync (good) and m_ready=1 in the same cycle -> level stays 4, drop_cnt unchanged, and the new frame is the last one popped.
REQ-023 Link timeout (LINK_TO=16): one good frame then idle -> link_up=1 for 16 cycles then 0; a bad frame mid-interval does not extend it.
REQ-024 Reset mid-stream: rst_n pulsed low with level=3 -> m_valid=0, level=0, counters=0 immediately; the next good frame appears after 1 cycle.

Source files
------------

// File: rtl/serial_msg_sink.sv
// Purpose: filters CRC-failed messages, buffers good ones in a FWFT FIFO, keeps frame stats and link liveness.
// Latency: 1 clk from a good sync strobe to m_valid/m_data on an empty FIFO.
// Backpressure: m_ready stalls the head; good frames arriving while full (and not popping) are dropped and counted.
module serial_msg_sink #(
    parameter int AW      = 2,
    parameter int LINK_TO = 500000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync,
    input  logic [63:0]   d,
    input  logic          err,
    input  logic          clr,
    output logic          m_valid,
    output logic [63:0]   m_data,
    input  logic          m_ready,
    output logic [AW:0]   level,
    output logic [15:0]   good_cnt,
    output logic [15:0]   bad_cnt,
    output logic [15:0]   drop_cnt,
    output logic          link_up
);

    localparam int DEPTH = 2 ** AW;
    // Watchdog wide enough for LINK_TO, never narrower than 20 bits.
    localparam int WW = ($clog2(LINK_TO + 1) > 20) ? $clog2(LINK_TO + 1) : 20;
    localparam logic [WW-1:0] WD_MAX   = WW'(LINK_TO);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [63:0]   r_m_data;
    logic [15:0]   r_good_cnt;
    logic [15:0]   r_bad_cnt;
    logic [15:0]   r_drop_cnt;
    logic [WW-1:0] r_wd;
    logic          r_link;

    logic          w_good;
    logic          w_bad;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW-1:0] w_rd_nxt;
    logic [AW:0]   w_lvl_after_pop;
    logic [63:0]   w_head_nxt;
    logic [WW-1:0] w_wd_nxt;

    // Frame classification and FIFO push/pop decisions; clr suppresses everything.
    always_comb begin
        w_good          = sync & ~err & ~clr;
        w_bad           = sync & err & ~clr;
        w_full          = (r_level == LVL_FULL);
        w_pop           = (r_level != '0) & m_ready & ~clr;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        w_push          = w_good & (~w_full | w_pop);
        w_drop          = w_good & w_full & ~w_pop;
        w_rd_nxt        = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_lvl_after_pop = w_pop ? r_level - (AW + 1)'(1) : r_level;
        // If nothing older remains, the incoming frame becomes the head.
        w_head_nxt      = (w_lvl_after_pop == '0) ? d : r_mem[w_rd_nxt];
        w_wd_nxt        = w_good ? '0 : ((r_wd == WD_MAX) ? r_wd : r_wd + WW'(1));
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= d;
    end

    // FIFO pointers, occupancy and registered head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_m_data <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_m_data <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_nxt;
            r_level  <= w_lvl_after_pop + (w_push ? (AW + 1)'(1) : '0);
            if (w_pop || (w_push && r_level == '0)) r_m_data <= w_head_nxt;
        end
    end

    // Saturating frame statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_drop_cnt <= '0;
        end else if (clr) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_good && r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 16'd1;
            if (w_bad  && r_bad_cnt  != 16'hFFFF) r_bad_cnt  <= r_bad_cnt  + 16'd1;
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // Link watchdog: restarts on each good frame, link drops once it saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd   <= WD_MAX;
            r_link <= 1'b0;
        end else if (clr) begin
            r_wd   <= WD_MAX;
            r_link <= 1'b0;
        end else begin
            r_wd   <= w_wd_nxt;
            r_link <= (w_wd_nxt != WD_MAX);
        end
    end

    assign m_valid  = (r_level != '0);
    assign m_data   = r_m_data;
    assign level    = r_level;
    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
    assign drop_cnt = r_drop_cnt;
    assign link_up  = r_link;

endmodule
